// File: rtl/soc_event_dispatch.sv
// soc_event_dispatch: drains per-source event queues one per cycle into an ID FIFO toward the FC event unit.
// Define SOC_EVENT_DISPATCH_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module soc_event_dispatch #(
    parameter int NB_EVENTS  = 8,
    parameter int ID_WIDTH   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NB_EVENTS-1:0]          event_pending_i,
    input  logic [NB_EVENTS-1:0]          event_mask_i,
    output logic [NB_EVENTS-1:0]          event_ack_o,
    output logic                          event_valid_o,
    output logic [ID_WIDTH-1:0]           event_id_o,
    input  logic                          event_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
    localparam int IDX_W = $clog2(NB_EVENTS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [NB_EVENTS-1:0] cand;
    logic [IDX_W-1:0]     base;
    logic [IDX_W-1:0]     j;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 gnt_vld;
    logic                 gnt;
    logic                 pop;
    logic [LVL_W-1:0]     level;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [IDX_W-1:0]     mem [FIFO_DEPTH];

    assign cand = event_pending_i & event_mask_i;

`ifdef SOC_EVENT_DISPATCH_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [IDX_W-1:0] ptr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            ptr <= '0;
        else if (gnt)
            ptr <= (gnt_idx == IDX_W'(NB_EVENTS - 1)) ? '0 : gnt_idx + 1'b1;
    end

    assign base = ptr;
`endif

    // Scan downward so the candidate closest to base is the last one written.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        j       = '0;
        for (int i = NB_EVENTS - 1; i >= 0; i--) begin
            j = IDX_W'((int'(base) + i) % NB_EVENTS);
            if (cand[j]) begin
                gnt_vld = 1'b1;
                gnt_idx = j;
            end
        end
    end

    // Only the registered level gates the grant; a same-cycle pop frees nothing.
    assign gnt           = gnt_vld && (level != LVL_W'(FIFO_DEPTH)) && !rst_i;
    assign event_ack_o   = gnt ? (NB_EVENTS'(1) << gnt_idx) : '0;
    assign event_valid_o = (level != '0);
    assign pop           = event_valid_o && event_ready_i;
    assign event_id_o    = event_valid_o ? ID_WIDTH'(mem[rd_ptr]) : '0;
    assign fifo_level_o  = level;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            level <= level + LVL_W'(gnt) - LVL_W'(pop);
            if (gnt)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (gnt)
            mem[wr_ptr] <= gnt_idx;
    end

    a_ack_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(event_ack_o));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) level <= LVL_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_soc_event_dispatch.sv
// tb_soc_event_dispatch: directed vectors for soc_event_dispatch in its default 8/8/4 configuration.
module tb_soc_event_dispatch;
    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] pend = 8'h00;
    logic [7:0] mask = 8'hFF;
    logic [7:0] ack;
    logic       valid;
    logic [7:0] id;
    logic       ready = 1'b0;
    logic [2:0] lvl;
    int         n_cmp = 0;
    int         n_err = 0;
    int         exp_rr [6] = '{0, 2, 5, 0, 2, 5};

    always #5 clk = ~clk;

    soc_event_dispatch #(.NB_EVENTS(8), .ID_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .event_pending_i(pend),
        .event_mask_i(mask),
        .event_ack_o(ack),
        .event_valid_o(valid),
        .event_id_o(id),
        .event_ready_i(ready),
        .fifo_level_o(lvl)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        // reset state, with pending present
        @(negedge clk); pend = 8'hFF; #1;
        chk("rst_ack", ack, 0); chk("rst_valid", valid, 0); chk("rst_id", id, 0); chk("rst_lvl", lvl, 0);
        // round-robin over 0,2,5 with ready held
        @(negedge clk); rst_i = 1'b0; pend = 8'h25; ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("rr_ack", ack, 32'(1) << exp_rr[i]);
            if (i > 0) begin
                chk("rr_valid", valid, 1);
                chk("rr_id", id, exp_rr[i-1]);
                chk("rr_lvl", lvl, 1);
            end
        end
        @(negedge clk); pend = 8'h00; #1;
        chk("rr_tail_ack", ack, 0); chk("rr_tail_id", id, 5);
        @(negedge clk); #1;
        chk("rr_drain_valid", valid, 0); chk("rr_drain_lvl", lvl, 0);
        // single event on queue 3
        @(negedge clk); pend = 8'h08; #1;
        chk("single_ack", ack, 8'h08);
        @(negedge clk); pend = 8'h00; #1;
        chk("single_ack_once", ack, 0); chk("single_valid", valid, 1); chk("single_id", id, 3); chk("single_lvl", lvl, 1);
        @(negedge clk); #1;
        chk("single_popped", valid, 0); chk("single_lvl0", lvl, 0); chk("single_id0", id, 0);
        // mask queue 4
        @(negedge clk); mask = 8'hEF; pend = 8'h50; #1;
        chk("mask_ack6", ack, 8'h40);
        @(negedge clk); pend = 8'h10; #1;
        chk("mask_blocked", ack, 0); chk("mask_id6", id, 6);
        @(negedge clk); mask = 8'hFF; #1;
        chk("mask_ack4", ack, 8'h10); chk("mask_lvl", lvl, 0);
        @(negedge clk); pend = 8'h00; #1;
        chk("mask_id4", id, 4); chk("mask_valid", valid, 1);
        @(negedge clk); #1;
        chk("mask_lvl0", lvl, 0);
        // fill the FIFO from queue 1
        @(negedge clk); ready = 1'b0; pend = 8'h02;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("fill_ack", ack, 8'h02);
            chk("fill_lvl", lvl, i);
        end
        @(negedge clk); #1;
        chk("full_ack", ack, 0); chk("full_lvl", lvl, 4); chk("full_id", id, 1);
        @(negedge clk); ready = 1'b1; #1;
        chk("full_pop_same_cycle", ack, 0);
        @(negedge clk); ready = 1'b0; #1;
        chk("full_resume_lvl", lvl, 3); chk("full_resume_ack", ack, 8'h02);
        @(negedge clk); #1;
        chk("full_again_lvl", lvl, 4); chk("full_again_ack", ack, 0);
        // asynchronous reset with level 3 and an active ack
        @(negedge clk); ready = 1'b1; #1;
        @(negedge clk); ready = 1'b0; #1;
        chk("pre_rst_lvl", lvl, 3); chk("pre_rst_ack", ack, 8'h02);
        rst_i = 1'b1; #1;
        chk("arst_ack", ack, 0); chk("arst_valid", valid, 0); chk("arst_lvl", lvl, 0); chk("arst_id", id, 0);
        @(negedge clk); pend = 8'h82; #1;
        chk("in_rst_ack", ack, 0);
        @(negedge clk); rst_i = 1'b0; #1;
        chk("restart_from0", ack, 8'h02);
        // simultaneous push/pop at level 2
        @(negedge clk); #1;
        chk("pp_ack7", ack, 8'h80); chk("pp_lvl1", lvl, 1);
        @(negedge clk); pend = 8'h80; ready = 1'b1; #1;
        chk("pp_lvl2", lvl, 2); chk("pp_id1", id, 1); chk("pp_ack", ack, 8'h80);
        @(negedge clk); pend = 8'h00; #1;
        chk("pp_lvl_hold", lvl, 2); chk("pp_id7a", id, 7); chk("pp_ack0", ack, 0);
        @(negedge clk); #1;
        chk("pp_lvl1b", lvl, 1); chk("pp_id7b", id, 7);
        @(negedge clk); #1;
        chk("pp_empty_valid", valid, 0); chk("pp_empty_lvl", lvl, 0); chk("pp_empty_id", id, 0);
        @(negedge clk); #1;
        chk("ready_no_valid_lvl", lvl, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
